// File: rtl/per_sync_pkg.sv
// per_sync_pkg: shared types and helpers for the CPU->peripheral SEND/DATA responder.
package per_sync_pkg;
    typedef enum logic {IDLE, ACK_HI} state_t;
    localparam int DATA_W_DEF = 32;
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/per_sync_fifo.sv
// per_sync_fifo: show-ahead word buffer; occupancy count is the only source of full/empty.
module per_sync_fifo
    import per_sync_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          push,
    input  logic [DATA_W-1:0]             pushData,
    input  logic                          pop,
    output logic [DATA_W-1:0]             headData,
    output logic                          notEmpty,
    output logic                          full,
    output logic [countWidth(DEPTH)-1:0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = countWidth(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign doPush   = push && !full;
    assign doPop    = pop && notEmpty;
    assign headData = mem[rdPtr];
    assign notEmpty = count != '0;
    assign full     = count == CW'(DEPTH);
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end
endmodule

// File: rtl/per_sync_responder.sv
// per_sync_responder: 4-phase ACK responder that buffers each SEND word in a FIFO.
// Optional PER_PARITY_EN adds even-parity checking with a sticky parity_err.
module per_sync_responder
    import per_sync_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                          clk_per,
    input  logic                          rst_per,
    input  logic                          SEND_per,
    input  logic [DATA_W-1:0]             inputData_per,
`ifdef PER_PARITY_EN
    input  logic                          inputParity_per,
    output logic                          parity_err,
`endif
    output logic                          outACK_per,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic [countWidth(DEPTH)-1:0]  count,
    output logic                          overrun
);
    state_t state, nextState;
    logic accept, parityOk;
    assign accept     = (state == IDLE) && SEND_per && !full;
    assign outACK_per = state == ACK_HI;
`ifdef PER_PARITY_EN
    assign parityOk = inputParity_per == ^inputData_per;
    always_ff @(posedge clk_per or negedge rst_per) begin
        if (!rst_per) parity_err <= 1'b0;
        else if (accept && !parityOk) parity_err <= 1'b1;
    end
`else
    assign parityOk = 1'b1;
`endif
    always_comb begin
        nextState = (state == IDLE) ? (accept ? ACK_HI : IDLE) : (SEND_per ? ACK_HI : IDLE);
    end
    always_ff @(posedge clk_per or negedge rst_per) begin
        if (!rst_per) begin
            state   <= IDLE;
            overrun <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && SEND_per && full) overrun <= 1'b1;
        end
    end
    per_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo (
        .clk(clk_per),
        .rstN(rst_per),
        .push(accept && parityOk),
        .pushData(inputData_per),
        .pop(rd_en),
        .headData(rd_data),
        .notEmpty(rd_valid),
        .full(full),
        .count(count)
    );
endmodule
